// File: rtl/hermitian_frame_scheduler.sv
// Ping-pong frame buffer between HermitianMapping and the IFFT: collects X[k] / X*[k]
// into bins k and FFT_N-k, zero-fills unwritten bins, streams frames in natural order.
module hermitian_frame_scheduler #(
  parameter int FFT_N    = 64,
  parameter int DATA_W   = 28,
  parameter int FIRST_SC = 5
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] DATA_IN_RE,
  input  logic [DATA_W-1:0] DATA_IN_IM,
  input  logic [15:0]       DATA_IN_INDEX,
  input  logic              DATA_IN_VALID,
  input  logic [DATA_W-1:0] DATA_IN_RE_HER,
  input  logic [DATA_W-1:0] DATA_IN_IM_HER,
  input  logic [15:0]       DATA_IN_INDEX_HER,
  input  logic              DATA_IN_VALID_HER,
  output logic              IN_READY,
  output logic [DATA_W-1:0] DATA_OUT_RE,
  output logic [DATA_W-1:0] DATA_OUT_IM,
  output logic [15:0]       DATA_OUT_INDEX,
  output logic              DATA_OUT_VALID,
  output logic              DATA_OUT_LAST,
  input  logic              DATA_OUT_READY,
  output logic              OVERFLOW,
  output logic              INDEX_ERR
);

  localparam int              AW       = $clog2(FFT_N);
  localparam logic [15:0]     LAST_K   = 16'(FFT_N / 2 - 1);
  localparam logic [15:0]     FIRST_K  = 16'(FIRST_SC);
  localparam logic [AW-1:0]   LAST_BIN = AW'(FFT_N - 1);

  typedef enum logic [1:0] {BK_EMPTY, BK_FULL, BK_DRAIN} bank_state_e;
  typedef enum logic {RD_IDLE, RD_STREAM} rd_state_e;

  logic [2*DATA_W-1:0] mem_q [2][FFT_N];
  logic [FFT_N-1:0]    mask_q [2];
  bank_state_e         bstate_q [2];
  logic                wb_q;
  logic                rb_q;
  rd_state_e           rd_state_q, rd_state_d;
  logic [AW-1:0]       addr_q, addr_d;

  logic [DATA_W-1:0]   out_re_q, out_im_q;
  logic [15:0]         out_idx_q;
  logic                out_valid_q, out_last_q;
  logic                ovf_q, err_q;

  logic                in_ready;
  logic                both_v, any_v, one_v, idx_eq, range_ok;
  logic                accept, close_frame, idx_bad, ovf_set;
  logic [AW-1:0]       k_addr, her_addr;
  logic                load, start, finish, chain;
  logic [2*DATA_W-1:0] rd_word;
  logic                rd_mask;

  // Input side: acceptance and error classification
  always_comb begin
    in_ready    = RST_N && (bstate_q[wb_q] == BK_EMPTY);
    both_v      = DATA_IN_VALID && DATA_IN_VALID_HER;
    any_v       = DATA_IN_VALID || DATA_IN_VALID_HER;
    one_v       = DATA_IN_VALID ^ DATA_IN_VALID_HER;
    idx_eq      = (DATA_IN_INDEX == DATA_IN_INDEX_HER);
    range_ok    = (DATA_IN_INDEX >= FIRST_K) && (DATA_IN_INDEX <= LAST_K);
    accept      = both_v && in_ready && idx_eq && range_ok;
    close_frame = accept && (DATA_IN_INDEX == LAST_K);
    idx_bad     = one_v || (both_v && (!idx_eq || !range_ok));
    ovf_set     = any_v && !in_ready;
    k_addr      = DATA_IN_INDEX[AW-1:0];
    her_addr    = ~k_addr + AW'(1);
  end

  // Reader FSM: chains straight into the other bank when it is already FULL
  always_comb begin
    rd_state_d = rd_state_q;
    addr_d     = addr_q;
    load       = 1'b0;
    start      = 1'b0;
    finish     = 1'b0;
    chain      = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        if (bstate_q[rb_q] == BK_FULL) begin
          rd_state_d = RD_STREAM;
          start      = 1'b1;
          addr_d     = '0;
        end
      end
      RD_STREAM: begin
        if (!out_valid_q || DATA_OUT_READY) begin
          load   = 1'b1;
          addr_d = addr_q + AW'(1);
          if (addr_q == LAST_BIN) begin
            finish = 1'b1;
            if (bstate_q[~rb_q] == BK_FULL) begin
              chain  = 1'b1;
              addr_d = '0;
            end else begin
              rd_state_d = RD_IDLE;
            end
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    rd_word = mem_q[rb_q][addr_q];
    rd_mask = mask_q[rb_q][addr_q];
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      mem_q[wb_q][k_addr]   <= {DATA_IN_RE, DATA_IN_IM};
      mem_q[wb_q][her_addr] <= {DATA_IN_RE_HER, DATA_IN_IM_HER};
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rd_state_q  <= RD_IDLE;
      addr_q      <= '0;
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      bstate_q[0] <= BK_EMPTY;
      bstate_q[1] <= BK_EMPTY;
      mask_q[0]   <= '0;
      mask_q[1]   <= '0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      addr_q     <= addr_d;
      if (start) bstate_q[rb_q] <= BK_DRAIN;
      if (load) begin
        out_valid_q <= 1'b1;
        out_re_q    <= rd_mask ? rd_word[2*DATA_W-1:DATA_W] : '0;
        out_im_q    <= rd_mask ? rd_word[DATA_W-1:0] : '0;
        out_idx_q   <= 16'(addr_q);
        out_last_q  <= (addr_q == LAST_BIN);
      end else if (DATA_OUT_READY) begin
        out_valid_q <= 1'b0;
      end
      if (finish) begin
        mask_q[rb_q]   <= '0;
        bstate_q[rb_q] <= BK_EMPTY;
        rb_q           <= ~rb_q;
        if (chain) bstate_q[~rb_q] <= BK_DRAIN;
      end
      // Placed after the drain clear so a same-cycle write keeps its mask bit
      if (accept) begin
        mask_q[wb_q][k_addr]   <= 1'b1;
        mask_q[wb_q][her_addr] <= 1'b1;
        if (close_frame) begin
          bstate_q[wb_q] <= BK_FULL;
          wb_q           <= ~wb_q;
        end
      end
      if (ovf_set) ovf_q <= 1'b1;
      if (idx_bad) err_q <= 1'b1;
    end
  end

  assign IN_READY       = in_ready;
  assign DATA_OUT_RE    = out_re_q;
  assign DATA_OUT_IM    = out_im_q;
  assign DATA_OUT_INDEX = out_idx_q;
  assign DATA_OUT_VALID = out_valid_q;
  assign DATA_OUT_LAST  = out_last_q;
  assign OVERFLOW       = ovf_q;
  assign INDEX_ERR      = err_q;

endmodule

// File: tb/tb_hermitian_frame_scheduler.sv
// Directed bench for hermitian_frame_scheduler: one task per scenario, expected bins
// computed from the Hermitian placement rule (bin k = X[k], bin N-k = X*[k]).
module tb_hermitian_frame_scheduler;

  localparam int DW = 28;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [DW-1:0] DATA_IN_RE = '0, DATA_IN_IM = '0, DATA_IN_RE_HER = '0, DATA_IN_IM_HER = '0;
  logic [15:0]   DATA_IN_INDEX = '0, DATA_IN_INDEX_HER = '0;
  logic          DATA_IN_VALID = 1'b0, DATA_IN_VALID_HER = 1'b0;
  logic          IN_READY;
  logic [DW-1:0] DATA_OUT_RE, DATA_OUT_IM;
  logic [15:0]   DATA_OUT_INDEX;
  logic          DATA_OUT_VALID, DATA_OUT_LAST;
  logic          DATA_OUT_READY = 1'b0;
  logic          OVERFLOW, INDEX_ERR;

  hermitian_frame_scheduler #(.FFT_N(64), .DATA_W(DW), .FIRST_SC(5)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .DATA_IN_RE(DATA_IN_RE), .DATA_IN_IM(DATA_IN_IM),
    .DATA_IN_INDEX(DATA_IN_INDEX), .DATA_IN_VALID(DATA_IN_VALID),
    .DATA_IN_RE_HER(DATA_IN_RE_HER), .DATA_IN_IM_HER(DATA_IN_IM_HER),
    .DATA_IN_INDEX_HER(DATA_IN_INDEX_HER), .DATA_IN_VALID_HER(DATA_IN_VALID_HER),
    .IN_READY(IN_READY),
    .DATA_OUT_RE(DATA_OUT_RE), .DATA_OUT_IM(DATA_OUT_IM),
    .DATA_OUT_INDEX(DATA_OUT_INDEX), .DATA_OUT_VALID(DATA_OUT_VALID),
    .DATA_OUT_LAST(DATA_OUT_LAST), .DATA_OUT_READY(DATA_OUT_READY),
    .OVERFLOW(OVERFLOW), .INDEX_ERR(INDEX_ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic [15:0]   idx;
    logic          last;
    int            cyc;
  } smp_t;

  smp_t mon_q[$];
  smp_t mon_s;
  // A beat valid and ready at the falling edge is accepted at the next rising edge
  always @(negedge CLK) begin
    if (DATA_OUT_VALID && DATA_OUT_READY) begin
      mon_s.re = DATA_OUT_RE; mon_s.im = DATA_OUT_IM; mon_s.idx = DATA_OUT_INDEX;
      mon_s.last = DATA_OUT_LAST; mon_s.cyc = cyc;
      mon_q.push_back(mon_s);
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [DW-1:0] exp_re(input int b, input int base, input logic [63:0] skip);
    int k;
    if (b >= 5 && b <= 31) k = b;
    else if (b >= 33 && b <= 59) k = 64 - b;
    else return '0;
    if (skip[k]) return '0;
    return DW'(base + k);
  endfunction

  function automatic logic [DW-1:0] exp_im(input int b, input int base, input logic [63:0] skip);
    int k;
    if (b >= 5 && b <= 31) k = b;
    else if (b >= 33 && b <= 59) k = 64 - b;
    else return '0;
    if (skip[k]) return '0;
    return (b <= 31) ? DW'(-(base + k)) : DW'(base + k);
  endfunction

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic idle_in();
    DATA_IN_VALID = 1'b0; DATA_IN_VALID_HER = 1'b0;
  endtask

  task automatic put(input logic v, input logic vh, input int k, input int kh,
                     input int re, input int im, input int reh, input int imh);
    DATA_IN_VALID = v; DATA_IN_VALID_HER = vh;
    DATA_IN_INDEX = 16'(k); DATA_IN_INDEX_HER = 16'(kh);
    DATA_IN_RE = DW'(re); DATA_IN_IM = DW'(im);
    DATA_IN_RE_HER = DW'(reh); DATA_IN_IM_HER = DW'(imh);
    tick();
  endtask

  task automatic do_reset();
    idle_in();
    RST_N = 1'b0;
    tick(); tick();
    RST_N = 1'b1;
    mon_q.delete();
  endtask

  // Sends k = 5..31 (minus skipped), waiting on IN_READY before each sample
  task automatic send_frame(input int base, input logic [63:0] skip, output int close_cyc,
                            output bit ok);
    int w;
    ok = 1'b1;
    close_cyc = 0;
    for (int k = 5; k <= 31; k++) begin
      if (!skip[k]) begin
        idle_in();
        w = 0;
        while (!IN_READY && w < 500) begin tick(); w++; end
        if (!IN_READY) ok = 1'b0;
        put(1'b1, 1'b1, k, k, base + k, -(base + k), base + k, base + k);
        close_cyc = cyc;
      end
    end
    idle_in();
  endtask

  task automatic wait_q(input int n, input int budget, output bit ok);
    for (int i = 0; i < budget && mon_q.size() < n; i++) tick();
    ok = (mon_q.size() >= n);
  endtask

  task automatic test_reset();
    idle_in();
    RST_N = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({DATA_OUT_VALID, DATA_OUT_LAST, OVERFLOW, INDEX_ERR} !== 4'b0 ||
        DATA_OUT_RE !== '0 || DATA_OUT_IM !== '0 || DATA_OUT_INDEX !== 16'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b l=%b ovf=%b err=%b re=%h im=%h idx=%0d, want all 0",
               DATA_OUT_VALID, DATA_OUT_LAST, OVERFLOW, INDEX_ERR, DATA_OUT_RE, DATA_OUT_IM,
               DATA_OUT_INDEX);
    end
    RST_N = 1'b1;
    tick();
    n_cmp++;
    if (IN_READY !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready: got %b, want 1", IN_READY);
    end
  endtask

  task automatic test_single_frame();
    int cc; bit ok; smp_t s;
    do_reset();
    DATA_OUT_READY = 1'b1;
    send_frame(0, '0, cc, ok);
    wait_q(64, 300, ok);
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL single_count: got %0d bins, want 64", mon_q.size());
      return;
    end
    n_cmp++;
    if (mon_q[0].cyc !== cc + 2) begin
      n_err++; $display("FAIL single_latency: got cycle %0d, want %0d", mon_q[0].cyc, cc + 2);
    end
    for (int i = 0; i < 64; i++) begin
      s = mon_q.pop_front();
      n_cmp++;
      if (s.idx !== 16'(i) || s.re !== exp_re(i, 0, '0) || s.im !== exp_im(i, 0, '0) ||
          s.last !== (i == 63) || s.cyc !== cc + 2 + i) begin
        n_err++;
        $display("FAIL single_bin%0d: got idx=%0d re=%h im=%h last=%b cyc=%0d, want idx=%0d re=%h im=%h last=%b cyc=%0d",
                 i, s.idx, s.re, s.im, s.last, s.cyc, i, exp_re(i, 0, '0), exp_im(i, 0, '0),
                 (i == 63), cc + 2 + i);
      end
    end
  endtask

  task automatic apply_bad(input int c);
    case (c)
      0: put(1'b1, 1'b1, 3, 3, 99, 99, 99, 99);
      1: put(1'b1, 1'b1, 40, 40, 99, 99, 99, 99);
      2: put(1'b1, 1'b1, 7, 8, 99, 99, 99, 99);
      default: put(1'b1, 1'b0, 10, 10, 99, 99, 99, 99);
    endcase
    idle_in();
  endtask

  task automatic test_index_err();
    int cc; bit ok; smp_t s; logic [63:0] skip;
    for (int c = 0; c < 4; c++) begin
      do_reset();
      apply_bad(c);
      n_cmp++;
      if (INDEX_ERR !== 1'b1 || OVERFLOW !== 1'b0) begin
        n_err++; $display("FAIL idxerr_case%0d: got err=%b ovf=%b, want err=1 ovf=0", c, INDEX_ERR, OVERFLOW);
      end
    end
    do_reset();
    DATA_OUT_READY = 1'b1;
    for (int c = 0; c < 4; c++) apply_bad(c);
    put(1'b1, 1'b0, 31, 31, 99, 99, 99, 99);
    idle_in();
    repeat (5) tick();
    n_cmp++;
    if (mon_q.size() != 0 || DATA_OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
      n_err++; $display("FAIL idxerr_no_close: got beats=%0d valid=%b ready=%b, want 0/0/1",
                        mon_q.size(), DATA_OUT_VALID, IN_READY);
    end
    skip = '0; skip[7] = 1'b1; skip[8] = 1'b1; skip[10] = 1'b1; skip[24] = 1'b1;
    send_frame(100, skip, cc, ok);
    wait_q(64, 300, ok);
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL idxerr_count: got %0d bins, want 64", mon_q.size());
      return;
    end
    for (int i = 0; i < 64; i++) begin
      s = mon_q.pop_front();
      n_cmp++;
      if (s.idx !== 16'(i) || s.re !== exp_re(i, 100, skip) || s.im !== exp_im(i, 100, skip)) begin
        n_err++;
        $display("FAIL idxerr_bin%0d: got idx=%0d re=%h im=%h, want re=%h im=%h",
                 i, s.idx, s.re, s.im, exp_re(i, 100, skip), exp_im(i, 100, skip));
      end
    end
  endtask

  task automatic test_back_to_back();
    int cc; bit ok; smp_t arr[$]; int gaps; int b;
    do_reset();
    DATA_OUT_READY = 1'b1;
    for (int f = 0; f < 3; f++) begin
      send_frame(f * 200, '0, cc, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL b2b_in_ready_f%0d: got stalled, want ready", f); end
    end
    wait_q(192, 1000, ok);
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL b2b_count: got %0d bins, want 192", mon_q.size());
      return;
    end
    arr = mon_q;
    mon_q.delete();
    gaps = 0;
    for (int i = 1; i < 192; i++) if (arr[i].cyc != arr[0].cyc + i) gaps++;
    n_cmp++;
    if (gaps != 0) begin n_err++; $display("FAIL b2b_contiguous: got %0d gaps, want 0", gaps); end
    for (int i = 0; i < 192; i++) begin
      b = i % 64;
      n_cmp++;
      if (arr[i].idx !== 16'(b) || arr[i].re !== exp_re(b, (i / 64) * 200, '0) ||
          arr[i].im !== exp_im(b, (i / 64) * 200, '0) || arr[i].last !== (b == 63)) begin
        n_err++;
        $display("FAIL b2b_beat%0d: got idx=%0d re=%h im=%h last=%b, want idx=%0d re=%h im=%h",
                 i, arr[i].idx, arr[i].re, arr[i].im, arr[i].last, b,
                 exp_re(b, (i / 64) * 200, '0), exp_im(b, (i / 64) * 200, '0));
      end
    end
    n_cmp++;
    if (OVERFLOW !== 1'b0) begin n_err++; $display("FAIL b2b_overflow: got %b, want 0", OVERFLOW); end
  endtask

  task automatic test_stall();
    int cc; bit ok; smp_t s; logic [3:0] pat;
    logic pv, pr; logic [DW-1:0] pre, pim; logic [15:0] pidx; logic plast; int c;
    do_reset();
    DATA_OUT_READY = 1'b1;
    send_frame(300, '0, cc, ok);
    pat = 4'b1001;
    c = 0;
    while (mon_q.size() < 64 && c < 600) begin
      DATA_OUT_READY = pat[c % 4];
      pv = DATA_OUT_VALID; pr = DATA_OUT_READY;
      pre = DATA_OUT_RE; pim = DATA_OUT_IM; pidx = DATA_OUT_INDEX; plast = DATA_OUT_LAST;
      tick();
      c++;
      if (pv && !pr) begin
        n_cmp++;
        if (DATA_OUT_VALID !== 1'b1 || DATA_OUT_RE !== pre || DATA_OUT_IM !== pim ||
            DATA_OUT_INDEX !== pidx || DATA_OUT_LAST !== plast) begin
          n_err++;
          $display("FAIL stall_hold: got v=%b idx=%0d re=%h im=%h, want v=1 idx=%0d re=%h im=%h",
                   DATA_OUT_VALID, DATA_OUT_INDEX, DATA_OUT_RE, DATA_OUT_IM, pidx, pre, pim);
        end
      end
    end
    DATA_OUT_READY = 1'b1;
    repeat (5) tick();
    n_cmp++;
    if (mon_q.size() != 64) begin
      n_err++; $display("FAIL stall_count: got %0d bins, want 64", mon_q.size());
      return;
    end
    for (int i = 0; i < 64; i++) begin
      s = mon_q.pop_front();
      n_cmp++;
      if (s.idx !== 16'(i) || s.re !== exp_re(i, 300, '0) || s.im !== exp_im(i, 300, '0)) begin
        n_err++;
        $display("FAIL stall_bin%0d: got idx=%0d re=%h im=%h, want re=%h im=%h",
                 i, s.idx, s.re, s.im, exp_re(i, 300, '0), exp_im(i, 300, '0));
      end
    end
  endtask

  task automatic test_overflow();
    int cc; bit ok; smp_t s; int base;
    do_reset();
    DATA_OUT_READY = 1'b0;
    send_frame(500, '0, cc, ok);
    send_frame(600, '0, cc, ok);
    n_cmp++;
    if (IN_READY !== 1'b0) begin n_err++; $display("FAIL ovf_in_ready: got %b, want 0", IN_READY); end
    for (int k = 5; k <= 10; k++) put(1'b1, 1'b1, k, k, 77, 77, 77, 77);
    idle_in();
    n_cmp++;
    if (OVERFLOW !== 1'b1 || INDEX_ERR !== 1'b0) begin
      n_err++; $display("FAIL ovf_set: got ovf=%b err=%b, want ovf=1 err=0", OVERFLOW, INDEX_ERR);
    end
    repeat (3) tick();
    n_cmp++;
    if (OVERFLOW !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b, want 1", OVERFLOW); end
    DATA_OUT_READY = 1'b1;
    wait_q(128, 400, ok);
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL ovf_count: got %0d bins, want 128", mon_q.size());
      return;
    end
    for (int i = 0; i < 128; i++) begin
      s = mon_q.pop_front();
      base = (i < 64) ? 500 : 600;
      n_cmp++;
      if (s.idx !== 16'(i % 64) || s.re !== exp_re(i % 64, base, '0) ||
          s.im !== exp_im(i % 64, base, '0)) begin
        n_err++;
        $display("FAIL ovf_beat%0d: got idx=%0d re=%h im=%h, want re=%h im=%h",
                 i, s.idx, s.re, s.im, exp_re(i % 64, base, '0), exp_im(i % 64, base, '0));
      end
    end
  endtask

  task automatic test_reset_mid();
    int cc; bit ok; smp_t s; int w;
    do_reset();
    DATA_OUT_READY = 1'b1;
    send_frame(800, '0, cc, ok);
    w = 0;
    while (!(DATA_OUT_VALID && DATA_OUT_INDEX == 16'd20) && w < 300) begin tick(); w++; end
    n_cmp++;
    if (!(DATA_OUT_VALID && DATA_OUT_INDEX == 16'd20)) begin
      n_err++; $display("FAIL midrst_reach20: got idx=%0d v=%b, want idx=20 v=1", DATA_OUT_INDEX, DATA_OUT_VALID);
    end
    RST_N = 1'b0;
    tick();
    n_cmp++;
    if (DATA_OUT_VALID !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b, want 0", DATA_OUT_VALID); end
    RST_N = 1'b1;
    mon_q.delete();
    repeat (80) tick();
    n_cmp++;
    if (mon_q.size() != 0) begin n_err++; $display("FAIL midrst_residue: got %0d beats, want 0", mon_q.size()); end
    send_frame(900, '0, cc, ok);
    wait_q(64, 300, ok);
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL midrst_count: got %0d bins, want 64", mon_q.size());
      return;
    end
    for (int i = 0; i < 64; i++) begin
      s = mon_q.pop_front();
      n_cmp++;
      if (s.idx !== 16'(i) || s.re !== exp_re(i, 900, '0) || s.im !== exp_im(i, 900, '0) ||
          s.last !== (i == 63)) begin
        n_err++;
        $display("FAIL midrst_bin%0d: got idx=%0d re=%h im=%h last=%b, want re=%h im=%h",
                 i, s.idx, s.re, s.im, s.last, exp_re(i, 900, '0), exp_im(i, 900, '0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_index_err();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
